// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared types, default timing constants and width helper
// for the key_conditioner push-button conditioner.
package key_cond_pkg;

  // Debounce FSM states
  typedef enum logic {
    KC_STABLE = 1'b0,
    KC_SETTLE = 1'b1
  } kc_state_t;

  // Default timing at 50 MHz: 10 ms debounce, 500 ms first repeat, 100 ms repeat period
  localparam int unsigned KC_DEBOUNCE_DEFAULT      = 32'd500000;
  localparam int unsigned KC_REPEAT_DELAY_DEFAULT  = 32'd25000000;
  localparam int unsigned KC_REPEAT_PERIOD_DEFAULT = 32'd5000000;

  // Counter width able to index a given cycle count (never narrower than one bit)
  function automatic int unsigned kc_cnt_width(input int unsigned cycles);
    if (cycles <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(cycles);
    end
  endfunction

endpackage

// File: rtl/key_cond_channel.sv
// key_cond_channel: one key bit -- 2-flop synchroniser, polarity
// normalisation, debounce FSM and (optionally) the auto-repeat counter.
// Optional feature macro: KEY_COND_REPEAT_EN (auto-repeat strobe).
module key_cond_channel
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KC_DEBOUNCE_DEFAULT,
  parameter int unsigned ACTIVE_LOW      = 32'd1,
  parameter int unsigned REPEAT_DELAY    = KC_REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = KC_REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int unsigned    CW        = kc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ZERO  = '0;
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 32'd1);
  // Raw level meaning "not pressed"; the synchroniser resets to it so a key
  // held through reset is seen as a fresh press.
  localparam logic           SYNC_IDLE = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_s;
  kc_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;

  // Two-flop synchroniser for the asynchronous raw key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= SYNC_IDLE;
      r_sync2 <= SYNC_IDLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Normalised key: 1 = pressed regardless of board polarity
  assign w_s = r_sync2 ^ SYNC_IDLE;

  // Debounce FSM with registered level and press/release strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= KC_STABLE;
      r_cnt     <= CNT_ZERO;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        KC_STABLE: begin
          if (w_s != r_level) begin
            r_cnt   <= CNT_ONE;
            r_state <= KC_SETTLE;
          end else begin
            r_cnt   <= CNT_ZERO;
          end
        end
        KC_SETTLE: begin
          if (w_s == r_level) begin
            // Glitch: input went back before the window closed
            r_cnt   <= CNT_ZERO;
            r_state <= KC_STABLE;
          end else if (r_cnt == CNT_LAST) begin
            r_level   <= w_s;
            r_cnt     <= CNT_ZERO;
            r_state   <= KC_STABLE;
            r_press   <= w_s;
            r_release <= ~w_s;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_cnt   <= CNT_ZERO;
          r_state <= KC_STABLE;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef KEY_COND_REPEAT_EN
  localparam int unsigned   RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   RW        = kc_cnt_width(RMAX + 32'd1);
  localparam logic [RW-1:0] REP_ZERO  = '0;
  localparam logic [RW-1:0] REP_ONE   = RW'(1);
  localparam logic [RW-1:0] REP_MAX   = RW'(RMAX);
  localparam logic [RW-1:0] REP_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_PER   = RW'(REPEAT_PERIOD);

  logic          w_commit;
  logic          w_commit_press;
  logic          w_commit_release;
  logic [RW-1:0] w_rep_target;
  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_first;
  logic          r_repeat;

  // Same-cycle view of the FSM committing a new level
  assign w_commit         = (r_state == KC_SETTLE) && (w_s != r_level) && (r_cnt == CNT_LAST);
  assign w_commit_press   = w_commit & w_s;
  assign w_commit_release = w_commit & ~w_s;
  assign w_rep_target     = r_rep_first ? REP_DELAY : REP_PER;

  // Auto-repeat: counts cycles since the last press/repeat strobe while held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt   <= REP_ZERO;
      r_rep_first <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (w_commit_press) begin
        r_rep_cnt   <= REP_ONE;
        r_rep_first <= 1'b1;
      end else if (w_commit_release || !r_level) begin
        // Release cycle and idle: no repeat, counter cleared
        r_rep_cnt   <= REP_ZERO;
        r_rep_first <= 1'b0;
      end else if (r_rep_cnt == w_rep_target) begin
        r_repeat    <= 1'b1;
        r_rep_cnt   <= REP_ONE;
        r_rep_first <= 1'b0;
      end else if (r_rep_cnt != REP_MAX) begin
        r_rep_cnt <= r_rep_cnt + REP_ONE;
      end else begin
        r_rep_cnt <= r_rep_cnt;
      end
    end
  end

  assign o_repeat = r_repeat;
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: N independent debounced key channels for the DE2-115
// game inputs. Optional auto-repeat enabled by defining KEY_COND_REPEAT_EN.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned CHANNELS        = 32'd4,
  parameter int unsigned DEBOUNCE_CYCLES = KC_DEBOUNCE_DEFAULT,
  parameter int unsigned ACTIVE_LOW      = 32'd1,
  parameter int unsigned REPEAT_DELAY    = KC_REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = KC_REPEAT_PERIOD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] keys_raw,
  output logic [CHANNELS-1:0] keys_level,
  output logic [CHANNELS-1:0] keys_press,
  output logic [CHANNELS-1:0] keys_release,
  output logic [CHANNELS-1:0] keys_repeat
);

  // One conditioner per key; the top only gathers the outputs
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    key_cond_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_raw     (keys_raw[g]),
      .o_level   (keys_level[g]),
      .o_press   (keys_press[g]),
      .o_release (keys_release[g]),
      .o_repeat  (keys_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench. Stimulus pushes hand-computed strobe
// events (cycle + vectors) into a time-ordered queue; a monitor pops and
// compares whenever the DUT shows any strobe.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keys_raw;
  logic [3:0] keys_level;
  logic [3:0] keys_press;
  logic [3:0] keys_release;
  logic [3:0] keys_repeat;

  int cyc     = 0;
  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int         at;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] rp;
  } ev_t;

  ev_t sb_q[$];
  ev_t mon_e;

  key_conditioner #(
    .CHANNELS        (4),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keys_raw     (keys_raw),
    .keys_level   (keys_level),
    .keys_press   (keys_press),
    .keys_release (keys_release),
    .keys_repeat  (keys_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Insert an expected event in cycle order, merging events on the same cycle
  task automatic expect_ev(input int at, input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] rp);
    ev_t e;
    int  idx;
    bit  done;
    idx  = sb_q.size();
    done = 1'b0;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (!done && sb_q[i].at == at) begin
        e = sb_q[i];
        e.pr = e.pr | pr;
        e.rl = e.rl | rl;
        e.rp = e.rp | rp;
        sb_q[i] = e;
        done = 1'b1;
      end else if (!done && sb_q[i].at > at && idx == sb_q.size()) begin
        idx = i;
      end
    end
    if (!done) begin
      e.at = at; e.pr = pr; e.rl = rl; e.rp = rp;
      sb_q.insert(idx, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every visible strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if ((keys_press | keys_release | keys_repeat) != 4'b0000) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: got press=%b release=%b repeat=%b at cycle %0d, expected none",
                 keys_press, keys_release, keys_repeat, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk_int("ev_cycle", cyc, mon_e.at);
        chk4("ev_press", keys_press, mon_e.pr);
        chk4("ev_release", keys_release, mon_e.rl);
        chk4("ev_repeat", keys_repeat, mon_e.rp);
      end
    end
  end

  initial begin
    int n;
    int r;
    rst_n    = 1'b0;
    keys_raw = 4'b0000;

    // Reset with all keys pressed: everything stays 0
    tick(3);
    chk4("rst_level", keys_level, 4'b0000);
    chk4("rst_press", keys_press, 4'b0000);
    chk4("rst_release", keys_release, 4'b0000);
    chk4("rst_repeat", keys_repeat, 4'b0000);
    rst_n = 1'b1;
    n = cyc;
    expect_ev(n + 6, 4'b1111, 4'b0000, 4'b0000);
    tick(8);
    chk4("held_through_reset_level", keys_level, 4'b1111);

    // Release all
    n = cyc;
    keys_raw = 4'b1111;
    expect_ev(n + 6, 4'b0000, 4'b1111, 4'b0000);
    tick(8);
    chk4("all_released_level", keys_level, 4'b0000);

    // Ch0 short glitches (3 samples, 1 high, 3 samples): never reported
    keys_raw[0] = 1'b0; tick(3);
    keys_raw[0] = 1'b1; tick(1);
    keys_raw[0] = 1'b0; tick(3);
    keys_raw[0] = 1'b1; tick(10);
    chk4("glitch_level", keys_level, 4'b0000);

    // Ch1 held 20 cycles
    n = cyc;
    keys_raw[1] = 1'b0;
    expect_ev(n + 6, 4'b0010, 4'b0000, 4'b0000);
    tick(10);
    chk4("ch1_held_level", keys_level, 4'b0010);
    tick(10);
    keys_raw[1] = 1'b1;
    expect_ev(n + 26, 4'b0000, 4'b0010, 4'b0000);
    tick(8);
    chk4("ch1_released_level", keys_level, 4'b0000);

    // Ch2 held 30 cycles: repeats 10,13,16.. after press when enabled
    n = cyc;
    keys_raw[2] = 1'b0;
    expect_ev(n + 6, 4'b0100, 4'b0000, 4'b0000);
`ifdef KEY_COND_REPEAT_EN
    for (int t = n + 16; t < n + 36; t += 3) expect_ev(t, 4'b0000, 4'b0000, 4'b0100);
`endif
    tick(15);
    chk4("ch2_held_level", keys_level, 4'b0100);
    tick(15);
    keys_raw[2] = 1'b1;
    expect_ev(n + 36, 4'b0000, 4'b0100, 4'b0000);
    tick(8);
    chk4("ch2_released_level", keys_level, 4'b0000);

    // Ch3 press, then ch0 press and ch3 release on the same edge.
    // Ch3's release lands where its first repeat would be: no repeat.
    n = cyc;
    keys_raw[3] = 1'b0;
    expect_ev(n + 6, 4'b1000, 4'b0000, 4'b0000);
    tick(10);
    keys_raw = 4'b1110;
    expect_ev(n + 16, 4'b0001, 4'b1000, 4'b0000);
    tick(8);
    chk4("ch0_only_level", keys_level, 4'b0001);
    keys_raw[0] = 1'b1;
    expect_ev(n + 24, 4'b0000, 4'b0001, 4'b0000);
    tick(8);
    chk4("simul_done_level", keys_level, 4'b0000);

    // Reset while ch0 pressed and ch1 mid-settle (cnt=2)
    n = cyc;
    keys_raw[0] = 1'b0;
    expect_ev(n + 6, 4'b0001, 4'b0000, 4'b0000);
    tick(3);
    keys_raw[1] = 1'b0;
    tick(4);
    chk4("pre_reset_level", keys_level, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk4("async_reset_level", keys_level, 4'b0000);
    chk4("async_reset_press", keys_press, 4'b0000);
    tick(3);
    rst_n = 1'b1;
    r = cyc;
    expect_ev(r + 6, 4'b0011, 4'b0000, 4'b0000);
    tick(8);
    chk4("fresh_press_level", keys_level, 4'b0011);
    n = cyc;
    keys_raw = 4'b1111;
    expect_ev(n + 6, 4'b0000, 4'b0011, 4'b0000);
    tick(8);
    chk4("final_level", keys_level, 4'b0000);

    chk_int("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
